rgmii_rx_frame: RTL and testbench



---
 rtl/rgmii_rx_frame.sv | 230 +++++++++++++++++++++++
 tb/tb_rgmii_rx_frame.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_frame.sv
// rgmii_rx_frame: byte-wide Ethernet receive framer in the PHY RX clock domain.
//
// The framer takes demuxed RGMII bytes and strips the preamble and SFD. It
// checks CRC-32 over the whole frame, holds back the FCS in a delay line, and
// emits the payload as a byte stream with last/error marking.
//
// Ports:
//   clk, reset   PHY receive clock; synchronous active-high reset
//   rx_data      demuxed receive byte
//   rx_ctl       [0] = RX_DV, [1] = RX_DV ^ RX_ER
//   out_data     payload byte
//   out_valid    out_data carries a payload byte this cycle
//   out_last     final payload byte of the frame
//   out_err      frame bad; meaningful only together with out_last
//   good_count   frames that ended without error (saturating)
//   bad_count    frames that ended with error, runts included (saturating)
//
// Output stream: out_valid, out_last and out_err are registered single-cycle
// pulses. There is no ready signal, so the consumer must take every beat that
// has out_valid high.
//
// Build option: define RX_FCS_KEEP_EN to keep the FCS. The delay line then
// shrinks to 1 entry, so the 4 FCS bytes are emitted as payload and out_last
// marks the final FCS byte.
module rgmii_rx_frame #(
    parameter int MAX_LEN = 1522,
    parameter int MIN_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic [1:0]       rx_ctl,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_err,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count
);

`ifdef RX_FCS_KEEP_EN
    localparam int DEPTH = 1;
`else
    localparam int DEPTH = 5;
`endif

    localparam int               LEN_W       = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT     = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_DEPTH   = LEN_W'(DEPTH);
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} state_t;

    // state is kept as a named enum so that checkers can bind to it directly.
    state_t           state;
    state_t           state_nx;

    logic             dv;
    logic             er;
    logic [7:0]       dl [DEPTH];
    logic [LEN_W-1:0] length;
    logic [31:0]      crc;
    logic             rx_err;

    logic             start;
    logic             push;
    logic             dl_full;
    logic             over;
    logic             frame_bad;
    logic             emit_valid;
    logic             emit_last;
    logic             emit_err;
    logic             good_inc;
    logic             bad_inc;

    assign dv = rx_ctl[0];
    assign er = rx_ctl[0] ^ rx_ctl[1];

    // Reflected CRC-32, processed LSB first. No final inversion is applied,
    // so a frame with a correct FCS leaves the fixed residue in the register.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // length counts the bytes pushed since the SFD, so it also tells how full
    // the delay line is.
    assign dl_full   = (length >= LEN_DEPTH);
    // The byte being pushed now would take the frame past MAX_LEN.
    assign over      = (length >= LEN_MAX);
    assign frame_bad = rx_err | (crc != CRC_RESIDUE) | (length < LEN_MIN);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_DROP;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (dv) begin
                    state_nx = (rx_data == 8'h55) ? ST_PRE : ST_DROP;
                end
            end
            ST_PRE: begin
                if (!dv) begin
                    state_nx = ST_IDLE;
                end else if (rx_data == 8'hD5) begin
                    state_nx = ST_DATA;
                end else if (rx_data != 8'h55) begin
                    state_nx = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!dv) begin
                    state_nx = ST_IDLE;
                end else if (over) begin
                    state_nx = ST_DROP;
                end
            end
            default: begin
                if (!dv) begin
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    // Output and datapath control.
    always_comb begin
        start      = 1'b0;
        push       = 1'b0;
        emit_valid = 1'b0;
        emit_last  = 1'b0;
        emit_err   = 1'b0;
        good_inc   = 1'b0;
        bad_inc    = 1'b0;
        case (state)
            ST_PRE: begin
                start = dv && (rx_data == 8'hD5);
            end
            ST_DATA: begin
                if (dv) begin
                    push       = 1'b1;
                    emit_valid = dl_full;
                    if (over) begin
                        emit_last = dl_full;
                        emit_err  = dl_full;
                        bad_inc   = 1'b1;
                    end
                end else if (dl_full) begin
                    // The oldest entry is the last payload byte. The newer
                    // entries are the FCS, which is dropped.
                    emit_valid = 1'b1;
                    emit_last  = 1'b1;
                    emit_err   = frame_bad;
                    good_inc   = !frame_bad;
                    bad_inc    = frame_bad;
                end else begin
                    bad_inc = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
            good_count <= '0;
            bad_count  <= '0;
            crc        <= 32'hFFFFFFFF;
            length     <= '0;
            rx_err     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dl[i] <= 8'h00;
            end
        end else begin
            out_valid <= emit_valid;
            out_last  <= emit_last;
            out_err   <= emit_err;
            out_data  <= emit_valid ? dl[DEPTH-1] : 8'h00;

            if (start) begin
                crc    <= 32'hFFFFFFFF;
                length <= '0;
                rx_err <= 1'b0;
            end else if (push) begin
                crc    <= crc_byte(crc, rx_data);
                rx_err <= rx_err | er;
                if (length != LEN_SAT) begin
                    length <= length + LEN_W'(1);
                end
                dl[0] <= rx_data;
                for (int i = 1; i < DEPTH; i++) begin
                    dl[i] <= dl[i-1];
                end
            end else if (state == ST_DATA) begin
                // dv fell: empty the delay line for the next frame.
                length <= '0;
            end

            if (good_inc && (good_count != CNT_MAX)) begin
                good_count <= good_count + CNT_W'(1);
            end
            if (bad_inc && (bad_count != CNT_MAX)) begin
                bad_count <= bad_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// tb_rgmii_rx_frame: directed testbench for rgmii_rx_frame.
//
// The DUT is built with MAX_LEN=100 so that an oversize frame stays short, and
// with CNT_W=2 so that counter saturation is reached in a few frames.
//
// The frame-level model predicts every payload beat and the cycle in which it
// appears. A single compare process checks the DUT outputs against that model
// on every cycle.
module tb_rgmii_rx_frame;

    localparam int TB_MAX_LEN = 100;
    localparam int TB_MIN_LEN = 64;
    localparam int TB_CNT_W   = 2;
    localparam int CNT_TOP    = (1 << TB_CNT_W) - 1;

    typedef logic [7:0] byte_q_t[$];

    logic                clk;
    logic                reset;
    logic [7:0]          rx_data;
    logic [1:0]          rx_ctl;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_err;
    logic [TB_CNT_W-1:0] good_count;
    logic [TB_CNT_W-1:0] bad_count;

    rgmii_rx_frame #(
        .MAX_LEN (TB_MAX_LEN),
        .MIN_LEN (TB_MIN_LEN),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ctl     (rx_ctl),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_err    (out_err),
        .good_count (good_count),
        .bad_count  (bad_count)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    // exp_q holds the expected beats as {last, err, data}; exp_cyc_q holds the
    // cycle in which each beat must appear.
    logic [9:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [9:0] exp_w;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_good = 0;
    int         exp_bad  = 0;
    int         beat_cnt = 0;
    int         first_cyc = -1;
    logic [7:0] last_data_seen = 8'h00;
    logic       last_err_seen = 1'b0;

    function automatic int sat_inc(input int v);
        return (v < CNT_TOP) ? v + 1 : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input bit last, input bit err, input int c);
        exp_q.push_back({last, err, d});
        exp_cyc_q.push_back(c);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (out_valid) begin
            beat_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            if (out_last) begin
                last_data_seen = out_data;
                last_err_seen  = out_err;
            end
            n_checks++;
            if (exp_q.size() == 0 || exp_cyc_q[0] != cyc) begin
                n_errors++;
                $display("FAIL beat_unexpected: cyc=%0d data=%02h last=%0d, required no beat", cyc, out_data, out_last);
            end else begin
                exp_w = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                check("beat_data", {24'h0, out_data}, {24'h0, exp_w[7:0]});
                check("beat_last", {31'h0, out_last}, {31'h0, exp_w[9]});
                if (exp_w[9]) check("beat_err", {31'h0, out_err}, {31'h0, exp_w[8]});
            end
        end else begin
            if (exp_q.size() != 0 && exp_cyc_q[0] == cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_missing: cyc=%0d got no beat, required data=%02h", cyc, exp_q[0][7:0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            n_checks++;
            if (out_last || out_err) begin
                n_errors++;
                $display("FAIL stray_flag: cyc=%0d last=%0d err=%0d without valid, required 0", cyc, out_last, out_err);
            end
        end
    end

    // ---------------- reference functions ----------------
    // Standard Ethernet CRC-32: init all ones, reflected, final inversion.
    function automatic logic [31:0] crc32(input byte_q_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input byte_q_t body);
        int n;
        n = body.size();
        return {body[n-1], body[n-2], body[n-3], body[n-4]} == crc32(body, n - 4);
    endfunction

    task automatic make_frame(input int npay, input int first, output byte_q_t f);
        logic [31:0] c;
        f = {};
        for (int i = 0; i < npay; i++) f.push_back(8'(first + i));
        c = crc32(f, npay);
        for (int j = 0; j < 4; j++) f.push_back(c[8*j +: 8]);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the falling edge. t is the cycle number
    // that the next rising edge turns into t+1.
    task automatic drive(input logic [7:0] d, input logic [1:0] ctl, output int t);
        @(negedge clk);
        #1;
        rx_data = d;
        rx_ctl  = ctl;
        t = cyc;
    endtask

    task automatic idle(input int n);
        int t;
        // dv=0 with in-band status bytes, which must be ignored.
        for (int i = 0; i < n; i++) drive(8'h55, 2'b10, t);
    endtask

    // Sends npre preamble bytes, the SFD, the body and then one dv=0 cycle.
    // The model predicts the outcome from the frame-level rules: payload
    // byte k appears one cycle after byte k+5 is sampled; the last payload
    // byte appears one cycle after dv falls; a frame longer than MAX_LEN ends
    // on the beat produced by its byte MAX_LEN+1.
    task automatic send_frame(input byte_q_t body, input int npre, input int er_idx, output int t_sfd);
        int t;
        int n;
        bit er_any;
        bit bad;
        n = body.size();
        er_any = 0;
        for (int i = 0; i < npre; i++) drive(8'h55, 2'b11, t);
        drive(8'hD5, 2'b11, t);
        t_sfd = t;
        for (int i = 0; i < n; i++) begin
            drive(body[i], (i == er_idx) ? 2'b01 : 2'b11, t);
            if (i <= TB_MAX_LEN) begin
                if (i == er_idx) er_any = 1;
                if (i >= 5) push_exp(body[i-5], i == TB_MAX_LEN, i == TB_MAX_LEN, t + 1);
                if (i == TB_MAX_LEN) exp_bad = sat_inc(exp_bad);
            end
        end
        drive(8'h00, 2'b00, t);
        if (n <= TB_MAX_LEN) begin
            if (n >= 5) begin
                bad = er_any || !fcs_ok(body) || (n < TB_MIN_LEN);
                push_exp(body[n-5], 1'b1, bad, t + 1);
                if (bad) exp_bad = sat_inc(exp_bad);
                else exp_good = sat_inc(exp_good);
            end else begin
                exp_bad = sat_inc(exp_bad);
            end
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_good"}, {30'h0, good_count}, 32'(exp_good));
        check({tag, "_bad"}, {30'h0, bad_count}, 32'(exp_bad));
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_obs();
        beat_cnt = 0;
        first_cyc = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        byte_q_t f1;
        byte_q_t f;
        byte_q_t s;
        int t;
        int t_sfd;

        reset   = 1'b1;
        rx_data = 8'h00;
        rx_ctl  = 2'b00;

        // CRC pin: CRC-32 of ASCII "123456789".
        s = {};
        for (int i = 0; i < 9; i++) s.push_back(8'(8'h31 + i));
        check("crc_pin", crc32(s, 9), 32'hCBF43926);

        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_last", {31'h0, out_last}, 32'd0);
        check("rst_err", {31'h0, out_err}, 32'd0);
        check("rst_good", {30'h0, good_count}, 32'd0);
        check("rst_bad", {30'h0, bad_count}, 32'd0);
        #1 reset = 1'b0;
        idle(3);

        // 1: good 60-byte payload frame
        make_frame(60, 0, f1);
        clear_obs();
        send_frame(f1, 7, -1, t_sfd);
        idle(3);
        check("t1_beats", 32'(beat_cnt), 32'd60);
        check("t1_last_data", {24'h0, last_data_seen}, 32'h3B);
        check("t1_last_err", {31'h0, last_err_seen}, 32'd0);
        check("t1_latency", 32'(first_cyc - t_sfd), 32'd7);
        check("t1_good_lit", {30'h0, good_count}, 32'd1);
        check_counts("t1");

        // 2: corrupted FCS byte 0
        f = f1;
        f[60] = f[60] ^ 8'h01;
        clear_obs();
        send_frame(f, 7, -1, t_sfd);
        idle(3);
        check("t2_beats", 32'(beat_cnt), 32'd60);
        check("t2_last_err", {31'h0, last_err_seen}, 32'd1);
        check("t2_bad_lit", {30'h0, bad_count}, 32'd1);
        check_counts("t2");

        // 3: RX_ER on payload byte 10
        clear_obs();
        send_frame(f1, 7, 10, t_sfd);
        idle(3);
        check("t3_last_err", {31'h0, last_err_seen}, 32'd1);
        check_counts("t3");

        // 4a: runt with three bytes after the SFD
        s = {8'hAA, 8'hBB, 8'hCC};
        clear_obs();
        send_frame(s, 1, -1, t_sfd);
        idle(3);
        check("t4_runt_beats", 32'(beat_cnt), 32'd0);
        check("t4_bad_lit", {30'h0, bad_count}, 32'd3);
        check_counts("t4a");

        // 4b: preamble abort
        drive(8'h55, 2'b11, t);
        drive(8'h12, 2'b11, t);
        drive(8'h00, 2'b00, t);
        idle(3);
        check("t4_abort_beats", 32'(beat_cnt), 32'd0);
        check_counts("t4b");

        // 5: oversize 120-byte frame; the bad counter is already saturated
        make_frame(116, 0, f);
        clear_obs();
        send_frame(f, 7, -1, t_sfd);
        idle(3);
        check("t5_beats", 32'(beat_cnt), 32'd96);
        check("t5_last_data", {24'h0, last_data_seen}, 32'h5F);
        check("t5_last_err", {31'h0, last_err_seen}, 32'd1);
        check("t5_bad_sat", {30'h0, bad_count}, 32'd3);
        check_counts("t5");

        // 6a: reset while dv=1 mid-payload
        for (int i = 0; i < 7; i++) drive(8'h55, 2'b11, t);
        drive(8'hD5, 2'b11, t);
        for (int i = 0; i < 20; i++) begin
            drive(f1[i], 2'b11, t);
            if (i >= 5) push_exp(f1[i-5], 1'b0, 1'b0, t + 1);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        rx_data = f1[20];
        exp_q = {};
        exp_cyc_q = {};
        exp_good = 0;
        exp_bad = 0;
        @(negedge clk);
        check("t6_rst_valid", {31'h0, out_valid}, 32'd0);
        check("t6_rst_last", {31'h0, out_last}, 32'd0);
        check("t6_rst_good", {30'h0, good_count}, 32'd0);
        check("t6_rst_bad", {30'h0, bad_count}, 32'd0);
        #1 reset = 1'b0;
        // The rest of the frame and a full frame with no dv gap are ignored.
        clear_obs();
        for (int i = 21; i < 64; i++) drive(f1[i], 2'b11, t);
        for (int i = 0; i < 7; i++) drive(8'h55, 2'b11, t);
        drive(8'hD5, 2'b11, t);
        for (int i = 0; i < 64; i++) drive(f1[i], 2'b11, t);
        drive(8'h00, 2'b00, t);
        check("t6_ignored_beats", 32'(beat_cnt), 32'd0);

        // 6b: two good frames separated by a single dv=0 cycle
        make_frame(60, 8'h40, f);
        send_frame(f1, 7, -1, t_sfd);
        send_frame(f, 7, -1, t_sfd);
        idle(3);
        check("t6_beats", 32'(beat_cnt), 32'd120);
        check("t6_good_lit", {30'h0, good_count}, 32'd2);
        check_counts("t6");

        // Boundaries: frame of exactly MAX_LEN bytes, then good-counter saturation
        make_frame(96, 8'h10, f);
        clear_obs();
        send_frame(f, 7, -1, t_sfd);
        idle(2);
        check("maxlen_beats", 32'(beat_cnt), 32'd96);
        send_frame(f1, 7, -1, t_sfd);
        idle(3);
        check("good_sat", {30'h0, good_count}, 32'd3);
        check_counts("sat");

        // Length exactly 5 (one beat), length 4 (none), length 14 (short)
        make_frame(1, 8'hA5, f);
        clear_obs();
        send_frame(f, 7, -1, t_sfd);
        idle(3);
        check("len5_beats", 32'(beat_cnt), 32'd1);
        check("len5_data", {24'h0, last_data_seen}, 32'hA5);
        check("len5_err", {31'h0, last_err_seen}, 32'd1);
        make_frame(0, 0, f);
        clear_obs();
        send_frame(f, 7, -1, t_sfd);
        idle(3);
        check("len4_beats", 32'(beat_cnt), 32'd0);
        make_frame(10, 8'h20, f);
        send_frame(f, 7, -1, t_sfd);
        idle(3);
        check("short_err", {31'h0, last_err_seen}, 32'd1);
        check_counts("short");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
